// File: rtl/fread_chunk_loader.sv
// rtl/fread_chunk_loader.sv - chunked fread loader into a byte buffer with UART-style dump and user read port
module fread_chunk_loader #(
  parameter int          DEPTH       = 12288,
  parameter int          CHUNK       = 2048,
  parameter int          ADDR_W      = 14,
  parameter logic [31:0] BASE_OFFSET = 32'h0,
  parameter bit          AUTO_DUMP   = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              dump_start,
  output logic              req_valid,
  input  logic              req_ready,
  output logic [31:0]       req_offset,
  output logic [15:0]       req_len,
  input  logic [7:0]        resp_data,
  input  logic              resp_valid,
  output logic [7:0]        uart_data,
  output logic              uart_valid,
  input  logic              uart_ack,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data,
  output logic              busy,
  output logic              loaded,
  output logic              led_loading
);

  localparam int              MEM_AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_P = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] LAST_P  = (ADDR_W+1)'(DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_RECV, S_LOADED, S_FETCH, S_SEND, S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [ADDR_W:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0] dump_ptr_q, dump_ptr_d;
  logic [15:0]     chunk_cnt_q, chunk_cnt_d;
  logic [15:0]     req_len_q, req_len_d;
  logic [31:0]     req_offset_q, req_offset_d;
  logic [7:0]      rd_data_q, uart_data_q;
  logic            mem_we;
  logic            rd_in_range;
  logic [7:0]      mem [DEPTH];

  // Bytes still missing from the buffer, capped at one chunk.
  function automatic logic [15:0] chunk_len(input logic [ADDR_W:0] ptr);
    logic [31:0] rem;
    rem = 32'(DEPTH_P - ptr);
    return (rem > 32'(CHUNK)) ? 16'(CHUNK) : 16'(rem);
  endfunction

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    dump_ptr_d   = dump_ptr_q;
    chunk_cnt_d  = chunk_cnt_q;
    req_len_d    = req_len_q;
    req_offset_d = req_offset_q;
    mem_we       = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d      = S_REQ;
          wr_ptr_d     = '0;
          req_offset_d = BASE_OFFSET;
          req_len_d    = chunk_len('0);
        end
      end
      S_REQ: begin
        if (req_ready) begin
          state_d     = S_RECV;
          chunk_cnt_d = '0;
        end
      end
      S_RECV: begin
        if (resp_valid) begin
          mem_we      = 1'b1;
          wr_ptr_d    = wr_ptr_q + 1'b1;
          chunk_cnt_d = chunk_cnt_q + 16'd1;
          if (chunk_cnt_d == req_len_q) begin
            if (wr_ptr_d == DEPTH_P) begin
              state_d    = S_LOADED;
              dump_ptr_d = '0;
            end else begin
              state_d      = S_REQ;
              req_offset_d = req_offset_q + {16'h0, req_len_q};
              req_len_d    = chunk_len(wr_ptr_d);
            end
          end
        end
      end
      S_LOADED: begin
        if (AUTO_DUMP || dump_start) state_d = S_FETCH;
      end
      S_FETCH: state_d = S_SEND;
      S_SEND: begin
        if (uart_ack) begin
          dump_ptr_d = dump_ptr_q + 1'b1;
          state_d    = (dump_ptr_q == LAST_P) ? S_DONE : S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      wr_ptr_q     <= '0;
      dump_ptr_q   <= '0;
      chunk_cnt_q  <= '0;
      req_len_q    <= '0;
      req_offset_q <= BASE_OFFSET;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      dump_ptr_q   <= dump_ptr_d;
      chunk_cnt_q  <= chunk_cnt_d;
      req_len_q    <= req_len_d;
      req_offset_q <= req_offset_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we && !rst) mem[wr_ptr_q[MEM_AW-1:0]] <= resp_data;
  end

  // Second port: dump fetch wins, user read data holds during FETCH.
  assign rd_in_range = ({1'b0, rd_addr} < DEPTH_P);

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q   <= 8'h00;
      uart_data_q <= 8'h00;
    end else if (state_q == S_FETCH) begin
      uart_data_q <= mem[dump_ptr_q[MEM_AW-1:0]];
    end else begin
      rd_data_q <= rd_in_range ? mem[rd_addr[MEM_AW-1:0]] : 8'h00;
    end
  end

  assign req_valid   = (state_q == S_REQ);
  assign req_offset  = req_offset_q;
  assign req_len     = req_len_q;
  assign uart_valid  = (state_q == S_SEND);
  assign uart_data   = uart_data_q;
  assign rd_data     = rd_data_q;
  assign busy        = (state_q == S_REQ) || (state_q == S_RECV) ||
                       (state_q == S_FETCH) || (state_q == S_SEND);
  assign loaded      = (state_q == S_LOADED) || (state_q == S_FETCH) ||
                       (state_q == S_SEND) || (state_q == S_DONE);
  assign led_loading = req_valid;

endmodule

// File: tb/tb_fread_chunk_loader.sv
// tb/tb_fread_chunk_loader.sv - scoreboard bench for fread_chunk_loader (unit 0 auto dump, unit 1 manual dump)
module tb_fread_chunk_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start[2], dump_start[2], req_ready[2], resp_valid[2], uart_ack[2];
  logic [7:0]  resp_data[2];
  logic [4:0]  rd_addr[2];
  logic        req_valid[2], uart_valid[2], busy[2], loaded[2], led_loading[2];
  logic [31:0] req_offset[2];
  logic [15:0] req_len[2];
  logic [7:0]  uart_data[2], rd_data[2];

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] exp_q0[$];
  logic [7:0] exp_q1[$];

  always #5 clk = ~clk;

  fread_chunk_loader #(.DEPTH(16), .CHUNK(8), .ADDR_W(5), .BASE_OFFSET(32'h100), .AUTO_DUMP(1'b1)) dut0 (
    .clk(clk), .rst(rst), .start(start[0]), .dump_start(dump_start[0]),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_offset(req_offset[0]), .req_len(req_len[0]),
    .resp_data(resp_data[0]), .resp_valid(resp_valid[0]),
    .uart_data(uart_data[0]), .uart_valid(uart_valid[0]), .uart_ack(uart_ack[0]),
    .rd_addr(rd_addr[0]), .rd_data(rd_data[0]),
    .busy(busy[0]), .loaded(loaded[0]), .led_loading(led_loading[0]));

  fread_chunk_loader #(.DEPTH(10), .CHUNK(4), .ADDR_W(5), .BASE_OFFSET(32'h200), .AUTO_DUMP(1'b0)) dut1 (
    .clk(clk), .rst(rst), .start(start[1]), .dump_start(dump_start[1]),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_offset(req_offset[1]), .req_len(req_len[1]),
    .resp_data(resp_data[1]), .resp_valid(resp_valid[1]),
    .uart_data(uart_data[1]), .uart_valid(uart_valid[1]), .uart_ack(uart_ack[1]),
    .rd_addr(rd_addr[1]), .rd_data(rd_data[1]),
    .busy(busy[1]), .loaded(loaded[1]), .led_loading(led_loading[1]));

  function automatic int chunk_of(input int u);
    return (u == 0) ? 8 : 4;
  endfunction

  function automatic logic [31:0] base_of(input int u);
    return (u == 0) ? 32'h100 : 32'h200;
  endfunction

  task automatic pulse_start(input int u);
    start[u] = 1'b1;
    @(negedge clk);
    start[u] = 1'b0;
  endtask

  // Serves every request of one full load; optionally stalls request number stall_req.
  task automatic load_image(input int u, input logic [7:0] img[$], input int stall_req);
    int wp, n, t, idx, bad;
    logic [31:0] eoff;
    wp = 0;
    idx = 0;
    while (wp < img.size()) begin
      n = (img.size() - wp < chunk_of(u)) ? img.size() - wp : chunk_of(u);
      eoff = base_of(u) + 32'(wp);
      t = 0;
      while (req_valid[u] !== 1'b1 && t < 50) begin
        @(negedge clk);
        t++;
      end
      vectors++;
      if (req_valid[u] !== 1'b1 || req_offset[u] !== eoff || req_len[u] !== 16'(n) || led_loading[u] !== 1'b1) begin
        miscompares++;
        $display("FAIL req u%0d #%0d: valid=%b off=%h len=%0d led=%b, required 1 %h %0d 1",
                 u, idx, req_valid[u], req_offset[u], req_len[u], led_loading[u], eoff, n);
      end
      if (idx == stall_req) begin
        bad = 0;
        for (int c = 0; c < 20; c++) begin
          resp_valid[u] = c[0];
          resp_data[u]  = 8'hEE;
          @(negedge clk);
          if (req_valid[u] !== 1'b1 || req_offset[u] !== eoff || req_len[u] !== 16'(n)) bad++;
        end
        resp_valid[u] = 1'b0;
        vectors++;
        if (bad != 0) begin
          miscompares++;
          $display("FAIL stall_hold u%0d: %0d cycles changed, required 0", u, bad);
        end
      end
      req_ready[u] = 1'b1;
      @(negedge clk);
      req_ready[u] = 1'b0;
      vectors++;
      if (req_valid[u] !== 1'b0 || busy[u] !== 1'b1) begin
        miscompares++;
        $display("FAIL accept u%0d: valid=%b busy=%b, required 0 1", u, req_valid[u], busy[u]);
      end
      for (int i = 0; i < n; i++) begin
        resp_valid[u] = 1'b1;
        resp_data[u]  = img[wp+i];
        if (u == 0) exp_q0.push_back(img[wp+i]);
        else        exp_q1.push_back(img[wp+i]);
        @(negedge clk);
      end
      resp_valid[u] = 1'b0;
      wp += n;
      idx++;
      vectors++;
      if (wp < img.size()) begin
        if (req_valid[u] !== 1'b1) begin
          miscompares++;
          $display("FAIL next_req_latency u%0d: valid=%b, required 1", u, req_valid[u]);
        end
      end else if (busy[u] !== 1'b0 || loaded[u] !== 1'b1 || req_valid[u] !== 1'b0) begin
        miscompares++;
        $display("FAIL loaded u%0d: busy=%b loaded=%b valid=%b, required 0 1 0", u, busy[u], loaded[u], req_valid[u]);
      end
    end
  endtask

  // Pops the scoreboard against each dumped byte; optional ack hold and start pulse mid-dump.
  task automatic dump_image(input int u, input int hold_first, input bit start_mid);
    int t, k, bad, left;
    logic [7:0] exp;
    k = 0;
    left = (u == 0) ? exp_q0.size() : exp_q1.size();
    while (left > 0) begin
      if (u == 0) exp = exp_q0.pop_front();
      else        exp = exp_q1.pop_front();
      t = 0;
      while (uart_valid[u] !== 1'b1 && t < 20) begin
        @(negedge clk);
        t++;
      end
      vectors++;
      if (uart_valid[u] !== 1'b1 || uart_data[u] !== exp) begin
        miscompares++;
        $display("FAIL dump u%0d byte %0d: valid=%b data=%h, required 1 %h", u, k, uart_valid[u], uart_data[u], exp);
      end
      if (k == 0 && hold_first > 0) begin
        bad = 0;
        repeat (hold_first) begin
          @(negedge clk);
          if (uart_valid[u] !== 1'b1 || uart_data[u] !== exp) bad++;
        end
        vectors++;
        if (bad != 0) begin
          miscompares++;
          $display("FAIL ack_hold u%0d: %0d cycles changed, required 0", u, bad);
        end
      end
      if (start_mid && k == 2) start[u] = 1'b1;
      uart_ack[u] = 1'b1;
      @(negedge clk);
      uart_ack[u] = 1'b0;
      start[u] = 1'b0;
      k++;
      left = (u == 0) ? exp_q0.size() : exp_q1.size();
    end
    vectors++;
    if (busy[u] !== 1'b0 || loaded[u] !== 1'b1 || uart_valid[u] !== 1'b0 || req_valid[u] !== 1'b0) begin
      miscompares++;
      $display("FAIL done u%0d: busy=%b loaded=%b uv=%b rv=%b, required 0 1 0 0",
               u, busy[u], loaded[u], uart_valid[u], req_valid[u]);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int u = 0; u < 2; u++) begin
      start[u] = 0; dump_start[u] = 0; req_ready[u] = 0; resp_valid[u] = 0;
      uart_ack[u] = 0; resp_data[u] = 8'h00; rd_addr[u] = 5'd0;
    end
    repeat (3) @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      vectors++;
      if (req_valid[u] !== 1'b0 || req_offset[u] !== base_of(u) || req_len[u] !== 16'd0) begin
        miscompares++;
        $display("FAIL reset_req u%0d: valid=%b off=%h len=%0d, required 0 %h 0", u, req_valid[u], req_offset[u], req_len[u], base_of(u));
      end
      vectors++;
      if (uart_valid[u] !== 1'b0 || uart_data[u] !== 8'h00 || rd_data[u] !== 8'h00) begin
        miscompares++;
        $display("FAIL reset_data u%0d: uv=%b ud=%h rd=%h, required 0 00 00", u, uart_valid[u], uart_data[u], rd_data[u]);
      end
      vectors++;
      if (busy[u] !== 1'b0 || loaded[u] !== 1'b0 || led_loading[u] !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_status u%0d: busy=%b loaded=%b led=%b, required 0 0 0", u, busy[u], loaded[u], led_loading[u]);
      end
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [7:0] img[$];
    for (int i = 0; i < 16; i++) img.push_back(8'(i));
    pulse_start(0);
    load_image(0, img, -1);
    dump_image(0, 0, 1'b0);
  endtask

  task automatic test_stall();
    logic [7:0] img[$];
    for (int i = 0; i < 16; i++) img.push_back(8'(i * 7 + 3));
    pulse_start(0);
    load_image(0, img, 1);
    dump_image(0, 0, 1'b0);
  endtask

  task automatic test_start_during_send();
    logic [7:0] img[$];
    for (int i = 0; i < 16; i++) img.push_back(8'(8'hA0 + i));
    pulse_start(0);
    load_image(0, img, -1);
    dump_image(0, 0, 1'b1);
    img.delete();
    for (int i = 0; i < 16; i++) img.push_back(8'($urandom_range(0, 255)));
    pulse_start(0);
    load_image(0, img, -1);
    dump_image(0, 0, 1'b0);
  endtask

  task automatic test_reset_mid_recv();
    logic [7:0] img[$];
    int t;
    pulse_start(0);
    req_ready[0] = 1'b1;
    @(negedge clk);
    req_ready[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      resp_valid[0] = 1'b1;
      resp_data[0]  = 8'h11;
      @(negedge clk);
    end
    resp_valid[0] = 1'b0;
    t = 0;
    while (req_valid[0] !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    req_ready[0] = 1'b1;
    @(negedge clk);
    req_ready[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      resp_valid[0] = 1'b1;
      resp_data[0]  = 8'h22;
      @(negedge clk);
    end
    resp_valid[0] = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    vectors++;
    if (req_valid[0] !== 1'b0 || busy[0] !== 1'b0 || loaded[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_recv: valid=%b busy=%b loaded=%b, required 0 0 0", req_valid[0], busy[0], loaded[0]);
    end
    for (int i = 0; i < 16; i++) img.push_back(8'(8'hF0 - i));
    pulse_start(0);
    load_image(0, img, -1);
    dump_image(0, 0, 1'b0);
  endtask

  task automatic test_short_chunk_manual_dump();
    logic [7:0] img[$];
    int bad;
    for (int i = 0; i < 10; i++) img.push_back(8'(8'h50 + i * 3));
    pulse_start(1);
    load_image(1, img, -1);
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (uart_valid[1] !== 1'b0 || loaded[1] !== 1'b1 || busy[1] !== 1'b0) bad++;
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL no_auto_dump: %0d bad cycles, required 0", bad);
    end
    rd_addr[1] = 5'd5;
    @(negedge clk);
    vectors++;
    if (rd_data[1] !== img[5]) begin
      miscompares++;
      $display("FAIL rd_addr5: got %h, required %h", rd_data[1], img[5]);
    end
    rd_addr[1] = 5'd9;
    @(negedge clk);
    vectors++;
    if (rd_data[1] !== img[9]) begin
      miscompares++;
      $display("FAIL rd_addr9: got %h, required %h", rd_data[1], img[9]);
    end
    dump_start[1] = 1'b1;
    @(negedge clk);
    dump_start[1] = 1'b0;
    dump_image(1, 7, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_start_during_send();
    test_reset_mid_recv();
    test_short_chunk_manual_dump();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

endmodule
